// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the TPU host command sequencer:
//   - host opcode values (OP_*)
//   - controller state enumeration (ctrl_state_t)
//   - is_valid_op(): true for opcodes the controller understands
// ---------------------------------------------------------------------------
package tpu_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD_W = 8'h01;
  localparam logic [7:0] OP_LOAD_X = 8'h02;
  localparam logic [7:0] OP_RUN    = 8'h03;
  localparam logic [7:0] OP_READ   = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_RADDR,
    ST_RDATA,
    ST_SEND
  } ctrl_state_t;

  // Opcodes are dense from NOP to READ, so one compare covers them all.
  function automatic logic is_valid_op(input logic [7:0] op);
    return (op <= OP_READ);
  endfunction

endpackage

// File: rtl/tpu_result_ser.sv
// ---------------------------------------------------------------------------
// tpu_result_ser
// Loads one ACC_W-bit result in parallel and emits it LSB-byte first over a
// valid/ready byte interface. o_done pulses with the final byte handshake.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_load       capture i_data and start emitting (next cycle)
//   i_data       parallel result word
//   i_ready      downstream accepts the current byte
//   o_data       current byte (low byte of the shift register)
//   o_valid      byte valid; data held stable until i_ready
//   o_done       combinational pulse on the last byte's handshake
// ---------------------------------------------------------------------------
module tpu_result_ser #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [ACC_W-1:0] i_data,
  input  logic             i_ready,
  output logic [7:0]       o_data,
  output logic             o_valid,
  output logic             o_done
);

  localparam int BYTES = ACC_W / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);

  logic [ACC_W-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_active;
  logic             w_fire;
  logic             w_last;

  assign w_fire = r_active & i_ready;
  assign w_last = (r_cnt == LAST_BYTE);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_shift  <= i_data;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (w_fire) begin
      r_shift <= r_shift >> 8;
      if (w_last) begin
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_data  = r_shift[7:0];
  assign o_valid = r_active;
  assign o_done  = w_fire & w_last;

endmodule

// File: rtl/tpu_host_ctrl.sv
// ---------------------------------------------------------------------------
// tpu_host_ctrl
// Byte-serial host command sequencer for the TPU core. Decodes host opcodes,
// streams operand bytes into the weight/input buffers, launches the systolic
// array and waits for completion, then serialises accumulator results back
// to the host with valid/ready backpressure.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_data/valid/ready   host command/payload byte stream
//   out_data/valid/ready  result byte stream to host
//   mem_we/sel/addr/wdata registered buffer write (sel 0=weight, 1=input)
//   arr_start, arr_done   array launch pulse / completion
//   res_addr, res_data    result read port (data one cycle after address)
//   busy                  controller not idle
//   err                   sticky bad-opcode flag, cleared by next good opcode
// ---------------------------------------------------------------------------
module tpu_host_ctrl
  import tpu_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int AW     = $clog2(N*N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              arr_start,
  input  logic              arr_done,
  output logic [AW-1:0]     res_addr,
  input  logic [ACC_W-1:0]  res_data,
  output logic              busy,
  output logic              err
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N*N - 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next_state;
  logic [AW-1:0]     r_index;
  logic              r_sel;
  logic              r_err;
  logic              r_we;
  logic [AW-1:0]     r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_ser_load;
  logic              w_ser_done;
  logic              w_last_idx;

  assign w_last_idx = (r_index == LAST_IDX);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    arr_start    = 1'b0;
    w_ser_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (in_data)
            OP_LOAD_W, OP_LOAD_X: w_next_state = ST_LOAD;
            OP_RUN:               w_next_state = ST_START;
            OP_READ:              w_next_state = ST_RADDR;
            default:              w_next_state = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && w_last_idx) w_next_state = ST_IDLE;
      end
      ST_START: begin
        arr_start    = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        // arr_done is only looked at here, so a stale level seen during
        // START cannot end the run early.
        if (arr_done) w_next_state = ST_IDLE;
      end
      ST_RADDR: w_next_state = ST_RDATA;
      ST_RDATA: begin
        w_ser_load   = 1'b1;
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        if (w_ser_done) w_next_state = w_last_idx ? ST_IDLE : ST_RADDR;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_index <= '0;
      r_sel   <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_err <= !is_valid_op(in_data);
            if (in_data == OP_LOAD_W || in_data == OP_LOAD_X) begin
              r_sel   <= (in_data == OP_LOAD_X);
              r_index <= '0;
            end
            if (in_data == OP_READ) r_index <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            r_we    <= 1'b1;
            r_waddr <= r_index;
            r_wdata <= DATA_W'(in_data);
            // Index parks at the last address instead of wrapping.
            if (!w_last_idx) r_index <= r_index + AW'(1);
          end
        end
        ST_SEND: begin
          if (w_ser_done && !w_last_idx) r_index <= r_index + AW'(1);
        end
        default: ;
      endcase
    end
  end

  tpu_result_ser #(.ACC_W(ACC_W)) u_ser (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_ser_load),
    .i_data  (res_data),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_valid (out_valid),
    .o_done  (w_ser_done)
  );

  assign mem_we    = r_we;
  assign mem_sel   = r_sel;
  assign mem_addr  = r_waddr;
  assign mem_wdata = r_wdata;
  assign res_addr  = r_index;
  assign busy      = (r_state != ST_IDLE);
  assign err       = r_err;

endmodule

// File: tb/tb_tpu_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tpu_host_ctrl
// Self-checking bench for tpu_host_ctrl. Expected write lists and result byte
// streams are built from the command semantics (queues/arrays), and compared
// with what a negedge monitor records from the DUT.
// ---------------------------------------------------------------------------
module tb_tpu_host_ctrl;

  localparam int N      = 2;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int AW     = $clog2(N*N);
  localparam int NN     = N*N;
  localparam int BYTES  = ACC_W/8;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              mem_we;
  logic              mem_sel;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              arr_start;
  logic              arr_done;
  logic [AW-1:0]     res_addr;
  logic [ACC_W-1:0]  res_data;
  logic              busy;
  logic              err;

  always #5 clk = ~clk;

  tpu_host_ctrl #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .arr_start(arr_start), .arr_done(arr_done),
    .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .err(err)
  );

  // Result memory model: one-cycle read latency.
  logic [ACC_W-1:0] res_table [NN];
  always @(posedge clk) res_data <= res_table[res_addr];

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] out_q[$];
  int         start_cnt  = 0;
  int         stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  int         n_pass  = 0;
  int         n_total = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) wr_q.push_back({mem_sel, mem_addr, mem_wdata});
    if (arr_start === 1'b1) start_cnt++;
    if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stall_viol++;
    prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
    prev_data  = out_data;
    if (out_valid === 1'b1 && out_ready === 1'b1) out_q.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and returns one step after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int   budget;
    logic acc;
    budget   = 50;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      budget--;
    end while (!acc && budget > 0);
    in_valid = 1'b0;
    if (!acc) begin
      n_total++;
      $display("FAIL send_byte_timeout: byte %h not accepted, in_ready=%b want 1", b, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; arr_done = 1'b0;
    repeat (3) tick();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++;
    if ({out_valid, mem_we, arr_start} !== 3'b000)
      $display("FAIL reset_strobes: out_valid/mem_we/arr_start got %b want 000", {out_valid, mem_we, arr_start});
    else n_pass++;
    n_total++;
    if ({busy, err} !== 2'b00) $display("FAIL reset_busy_err: got %b want 00", {busy, err}); else n_pass++;
    n_total++;
    if ({out_data, mem_sel, mem_addr, mem_wdata, res_addr} !== '0)
      $display("FAIL reset_buses: out_data=%h mem_sel=%b mem_addr=%h mem_wdata=%h res_addr=%h want all 0",
               out_data, mem_sel, mem_addr, mem_wdata, res_addr);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  // Sends opcode + NN payload bytes with optional random gaps, checks writes.
  task automatic test_load(input logic sel, input logic use_plan_data, input logic rand_gaps);
    logic [7:0] bytes [NN];
    wr_t        exp;
    for (int i = 0; i < NN; i++)
      bytes[i] = use_plan_data ? 8'(8'h11 * (i + 1)) : 8'($urandom_range(0, 255));
    wr_q.delete();
    send_byte(sel ? 8'h02 : 8'h01);
    for (int i = 0; i < NN; i++) begin
      send_byte(bytes[i]);
      if (i == NN - 1) begin
        // Final strobe lands in the first IDLE cycle.
        n_total++;
        if ({mem_we, busy} !== 2'b10)
          $display("FAIL load_last_strobe: mem_we/busy got %b want 10", {mem_we, busy});
        else n_pass++;
      end else if (use_plan_data && i == 1) begin
        repeat (2) tick();
      end else if (rand_gaps) begin
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    tick();
    n_total++;
    if (wr_q.size() != NN) $display("FAIL load_count: got %0d writes want %0d", wr_q.size(), NN); else n_pass++;
    for (int i = 0; i < NN && i < wr_q.size(); i++) begin
      exp = {sel, AW'(i), bytes[i]};
      n_total++;
      if (wr_q[i] !== exp)
        $display("FAIL load_write%0d: got sel=%b addr=%0d data=%h want sel=%b addr=%0d data=%h",
                 i, wr_q[i].sel, wr_q[i].addr, wr_q[i].data, exp.sel, exp.addr, exp.data);
      else n_pass++;
    end
    n_total++;
    if ({busy, err} !== 2'b00) $display("FAIL load_idle: busy/err got %b want 00", {busy, err}); else n_pass++;
  endtask

  // RUN: optional arr_done pulse during START (must be ignored), then done
  // raised after wait_cycles; busy/in_ready checked every cycle in between.
  task automatic test_run(input int wait_cycles, input logic early_done);
    int bad;
    bad = 0;
    start_cnt = 0;
    send_byte(8'h03);
    if (early_done) begin
      arr_done = 1'b1;
      tick();
      arr_done = 1'b0;
    end
    for (int c = 0; c < wait_cycles; c++) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL run_busy_window: %0d cycles with busy!=1 or in_ready!=0, want 0", bad); else n_pass++;
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    n_total++;
    if ({busy, in_ready} !== 2'b01) $display("FAIL run_done_idle: busy/in_ready got %b want 01", {busy, in_ready}); else n_pass++;
    tick();
    n_total++;
    if (start_cnt != 1) $display("FAIL run_start_pulse: got %0d cycles want 1", start_cnt); else n_pass++;
  endtask

  // READ: mode 0 = plan table A000+addr with toggling out_ready,
  //       1 = random table, random out_ready, 2 = random table, out_ready=1
  //       (also checks per-result overhead of 2 + BYTES cycles).
  task automatic test_read(input int mode);
    logic [7:0]       exp_q[$];
    logic [ACC_W-1:0] t;
    int               cycles;
    for (int a = 0; a < NN; a++)
      res_table[a] = (mode == 0) ? ACC_W'(16'hA000 + a) : ACC_W'($urandom);
    for (int a = 0; a < NN; a++)
      for (int b = 0; b < BYTES; b++) begin
        t = res_table[a] >> (8*b);
        exp_q.push_back(t[7:0]);
      end
    out_q.delete();
    stall_viol = 0;
    out_ready  = (mode == 2);
    send_byte(8'h04);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      if (mode == 0) out_ready = ~out_ready;
      else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    out_ready = 1'b0;
    tick();
    n_total++;
    if (busy !== 1'b0) $display("FAIL read_timeout: busy=%b after %0d cycles want 0", busy, cycles); else n_pass++;
    n_total++;
    if (out_q.size() != exp_q.size())
      $display("FAIL read_count: got %0d bytes want %0d", out_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_total++;
      if (out_q[i] !== exp_q[i]) $display("FAIL read_byte%0d: got %h want %h", i, out_q[i], exp_q[i]); else n_pass++;
    end
    n_total++;
    if (stall_viol != 0) $display("FAIL read_stable: %0d unstable stall cycles want 0", stall_viol); else n_pass++;
    if (mode == 2) begin
      // Cycle after accepting READ is RADDR; busy for NN*(2+BYTES) cycles.
      n_total++;
      if (cycles != NN*(2+BYTES))
        $display("FAIL read_throughput: got %0d busy cycles want %0d", cycles, NN*(2+BYTES));
      else n_pass++;
    end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] op;
    for (int k = 0; k < 3; k++) begin
      op = (k == 0) ? 8'h7F : 8'($urandom_range(5, 255));
      send_byte(op);
      n_total++;
      if ({err, in_ready, busy} !== 3'b110)
        $display("FAIL bad_op_%h: err/in_ready/busy got %b want 110", op, {err, in_ready, busy});
      else n_pass++;
    end
    send_byte(8'h00);
    n_total++;
    if ({err, busy} !== 2'b00) $display("FAIL nop_clears_err: err/busy got %b want 00", {err, busy}); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] bytes [NN];
    wr_t        exp;
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr_q.delete();
    n_total++;
    if ({busy, in_ready, mem_we} !== 3'b010)
      $display("FAIL midload_reset: busy/in_ready/mem_we got %b want 010", {busy, in_ready, mem_we});
    else n_pass++;
    bytes[0] = 8'hCC;
    for (int i = 1; i < NN; i++) bytes[i] = 8'($urandom_range(0, 255));
    send_byte(8'h02);
    for (int i = 0; i < NN; i++) send_byte(bytes[i]);
    tick();
    n_total++;
    if (wr_q.size() != NN) $display("FAIL midload_count: got %0d writes want %0d", wr_q.size(), NN); else n_pass++;
    for (int i = 0; i < NN && i < wr_q.size(); i++) begin
      exp = {1'b1, AW'(i), bytes[i]};
      n_total++;
      if (wr_q[i] !== exp)
        $display("FAIL midload_write%0d: got sel=%b addr=%0d data=%h want sel=%b addr=%0d data=%h",
                 i, wr_q[i].sel, wr_q[i].addr, wr_q[i].data, exp.sel, exp.addr, exp.data);
      else n_pass++;
    end
  endtask

  initial begin
    for (int a = 0; a < NN; a++) res_table[a] = ACC_W'(16'hA000 + a);
    #1;
    test_reset();
    test_load(1'b0, 1'b1, 1'b0);
    test_load(1'b1, 1'b0, 1'b1);
    test_load(1'b0, 1'b0, 1'b1);
    test_run(10, 1'b0);
    test_run($urandom_range(2, 15), 1'b1);
    test_read(0);
    test_read(1);
    test_read(2);
    test_bad_opcode();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tpu_host_ctrl.md
Name: tpu_host_ctrl

Overview:
- Byte-serial host command sequencer for the TPU core; sits between the 8-bit pin-level host stream and the N×N systolic array.
- Decodes opcodes and streams operand bytes into the weight/input buffers.
- Launches the array and waits for completion, then serialises accumulator results back to the host with valid/ready backpressure.

Parameters:
- N, 2, array dimension; buffers hold N*N entries.
- DATA_W, 8, operand width; equals host byte width.
- ACC_W, 16, result width; must be a multiple of 8; BYTES = ACC_W/8.
- AW, $clog2(N*N), buffer/result address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  8  host command/payload byte
- in_valid  in  1  host byte valid
- in_ready  out  1  controller accepts byte
- out_data  out  8  result byte to host
- out_valid  out  1  result byte valid
- out_ready  in  1  host accepts result byte
- mem_we  out  1  buffer write strobe
- mem_sel  out  1  0 = weight buffer, 1 = input buffer
- mem_addr  out  AW  buffer write address
- mem_wdata  out  DATA_W  buffer write data
- arr_start  out  1  one-cycle compute launch pulse
- arr_done  in  1  array finished (pulse or level; sampled high once)
- res_addr  out  AW  result read address
- res_data  in  ACC_W  result data, valid one cycle after res_addr
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky bad-opcode flag

Behaviour:
- Clock is clk; reset is synchronous and active-high, named reset. Reset returns to IDLE and clears all counters.
- Reset values: in_ready=1, every other output 0.
- A byte transfers when in_valid & in_ready.
- Opcodes, accepted in IDLE only:
  - 0x00 NOP
  - 0x01 LOAD_W
  - 0x02 LOAD_X
  - 0x03 RUN
  - 0x04 READ
- Any other opcode: consumed; err<=1; stay IDLE. err clears when the next valid opcode (including NOP) is accepted.
- States: IDLE, LOAD, START, WAIT, RADDR, RDATA, SEND.
- IDLE:
  - 0x01 or 0x02 -> LOAD; mem_sel latched (0 for LOAD_W, 1 for LOAD_X); index cleared.
  - 0x03 -> START.
  - 0x04 -> RADDR; index cleared.
- LOAD:
  - in_ready=1.
  - Each accepted byte produces a registered write on the next cycle: mem_we=1, mem_addr=index, mem_wdata=byte. Index then increments.
  - After byte N*N-1 is accepted -> IDLE. The final write strobe occurs in the first IDLE cycle.
  - Host gaps (in_valid low) stall the count; there is no timeout.
- START: arr_start=1 for exactly one cycle -> WAIT.
- WAIT:
  - in_ready=0.
  - arr_done=1 -> IDLE next cycle.
  - arr_done already high in the START cycle is ignored; only WAIT samples it.
- RADDR: res_addr=index -> RDATA.
- RDATA: capture res_data into a shift register; byte counter cleared -> SEND.
- SEND:
  - out_valid=1; out_data = low byte of the shift register first.
  - out_data and out_valid stay stable until out_ready.
  - On handshake, shift right 8 bits.
  - After BYTES handshakes: if index==N*N-1 -> IDLE, else index++ -> RADDR.
- in_ready is 1 only in IDLE and LOAD.
- Reset mid-operation: any partial load or read is abandoned. The next LOAD restarts at address 0.
- Per-result overhead is 2 cycles plus BYTES handshake cycles. No bubble between the bytes of one result.
- Index width is AW; it never wraps, because the terminal compare is against N*N-1.

Decomposition:
- tpu_pkg holds:
  - opcode localparams OP_NOP, OP_LOAD_W, OP_LOAD_X, OP_RUN, OP_READ
  - state enum ctrl_state_t
- One natural sub-module, tpu_result_ser: takes an ACC_W parallel load and emits bytes over valid/ready, with a done pulse. Used by the RDATA/SEND path.

Test Plan:
1. Reset: hold reset 3 cycles -> in_ready=1; out_valid, mem_we, arr_start, busy, err all 0.
2. LOAD_W: send 0x01 then 0x11, 0x22, 0x33, 0x44 with a 2-cycle gap after 0x22 -> mem_we pulses at addr 0..3, sel=0, data 0x11..0x44, in order; then busy=0.
3. RUN: send 0x03; model raises arr_done 10 cycles later -> arr_start high exactly 1 cycle; busy=1 and in_ready=0 until the cycle after arr_done.
4. READ with backpressure:
   - Setup: res_data = 16'hA000 + res_addr (1-cycle latency); send 0x04; out_ready toggles every other cycle.
   - Required: byte stream 00 A0 01 A0 02 A0 03 A0; out_data stable while out_ready=0.
5. Bad opcode: send 0x7F -> err=1, in_ready stays 1. Then send 0x00 -> err=0.
6. Reset mid-LOAD: send 0x02, 0xAA, 0xBB, then reset 1 cycle, then 0x02, 0xCC -> write of 0xCC at addr 0 with sel=1.
